// File: rtl/cardio_dtree_pkg.sv
// cardio_dtree_pkg: shared types and the constant node table for the CTG
// decision-tree classifier.
//   node_t : {is_leaf, feat[4:0], thr[7:0], left[5:0], right[5:0], cls[1:0]}
//   walk_t : traversal state handed between chained node evaluators
//   DTREE_NODES / dtree_node() : default 7-entry tree and its lookup
package cardio_dtree_pkg;

  localparam int FEAT_IDX_W = 5;
  localparam int NODE_IDX_W = 6;
  localparam int THR_W      = 8;
  localparam int NUM_FEATS  = 20;
  localparam int TABLE_LEN  = 7;

  localparam logic [1:0] CLASS_NORMAL  = 2'd0;
  localparam logic [1:0] CLASS_SUSPECT = 2'd1;
  localparam logic [1:0] CLASS_PATHO   = 2'd2;

  typedef struct packed {
    logic                  is_leaf;
    logic [FEAT_IDX_W-1:0] feat;
    logic [THR_W-1:0]      thr;
    logic [NODE_IDX_W-1:0] left;
    logic [NODE_IDX_W-1:0] right;
    logic [1:0]            cls;
  } node_t;

  // done=1 once a leaf (or a malformed-table condition) has fixed cls;
  // otherwise idx names the internal node still to be evaluated.
  typedef struct packed {
    logic                  done;
    logic [NODE_IDX_W-1:0] idx;
    logic [1:0]            cls;
  } walk_t;

  localparam node_t DTREE_NODES [TABLE_LEN] = '{
    '{1'b0, 5'd8,  8'd100, 6'd1, 6'd2, CLASS_NORMAL},   // n0: X8  <= 100
    '{1'b0, 5'd1,  8'd20,  6'd3, 6'd4, CLASS_NORMAL},   // n1: X1  <= 20
    '{1'b0, 5'd17, 8'd50,  6'd5, 6'd6, CLASS_NORMAL},   // n2: X17 <= 50
    '{1'b1, 5'd0,  8'd0,   6'd0, 6'd0, CLASS_SUSPECT},  // n3
    '{1'b1, 5'd0,  8'd0,   6'd0, 6'd0, CLASS_NORMAL},   // n4
    '{1'b1, 5'd0,  8'd0,   6'd0, 6'd0, CLASS_PATHO},    // n5
    '{1'b1, 5'd0,  8'd0,   6'd0, 6'd0, CLASS_SUSPECT}   // n6
  };

  // Entries past the populated table read as a normal-class leaf.
  function automatic node_t dtree_node(input logic [NODE_IDX_W-1:0] idx);
    node_t n;
    n = '{1'b1, 5'd0, 8'd0, 6'd0, 6'd0, CLASS_NORMAL};
    for (int i = 0; i < TABLE_LEN; i++)
      if (idx == NODE_IDX_W'(i)) n = DTREE_NODES[i];
    return n;
  endfunction

endpackage

// File: rtl/cardio_dtree_classifier_node_eval.sv
// dtree_node_eval: one combinational traversal step.
//   feats_i : all 20 feature slots (unused slots already zero)
//   walk_i  : incoming traversal state
//   walk_o  : state after one comparison; resolves immediately when the
//             chosen child is a leaf so N steps cover N comparisons.
module dtree_node_eval
  import cardio_dtree_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_NODES = 7,
  parameter int DEF_CLASS = 0
) (
  input  logic [NUM_FEATS-1:0][DATA_W-1:0] feats_i,
  input  walk_t                            walk_i,
  output walk_t                            walk_o
);

  node_t                 cur, nxt;
  logic [DATA_W-1:0]     fval;
  logic [NODE_IDX_W-1:0] child;
  logic                  unused_nxt;

  assign cur = dtree_node(walk_i.idx);
  // Feature indices beyond the implemented slots read as zero.
  assign fval  = (cur.feat < FEAT_IDX_W'(NUM_FEATS)) ? feats_i[cur.feat] : '0;
  assign child = (fval <= DATA_W'(cur.thr)) ? cur.left : cur.right;
  assign nxt   = dtree_node(child);
  assign unused_nxt = ^{nxt.feat, nxt.thr, nxt.left, nxt.right};

  always_comb begin
    walk_o = walk_i;
    if (!walk_i.done) begin
      if (int'(walk_i.idx) >= NUM_NODES) begin
        walk_o.done = 1'b1;
        walk_o.cls  = 2'(DEF_CLASS);
      end else if (cur.is_leaf) begin
        walk_o.done = 1'b1;
        walk_o.cls  = cur.cls;
      end else if (int'(child) >= NUM_NODES) begin
        walk_o.done = 1'b1;
        walk_o.cls  = 2'(DEF_CLASS);
      end else if (nxt.is_leaf) begin
        walk_o.done = 1'b1;
        walk_o.cls  = nxt.cls;
      end else begin
        walk_o.idx  = child;
      end
    end
  end

endmodule

// File: rtl/cardio_dtree_classifier.sv
// cardio_dtree_classifier: three-class CTG decision-tree classifier.
//   clk, rst_n      : rising-edge clock, async active-low reset
//   X0..X3, X6..X19 : unsigned features (slots 4 and 5 are tied to zero)
//   out             : registered class (0 normal, 1 suspect, 2 pathological)
// Optional macro DTREE_IN_REG_EN adds a feature input register (latency 2).
module cardio_dtree_classifier
  import cardio_dtree_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLASS_W   = 2,
  parameter int NUM_NODES = 7,
  parameter int MAX_DEPTH = 8,
  parameter int DEF_CLASS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  X0,  X1,  X2,  X3,
  input  logic [DATA_W-1:0]  X6,  X7,  X8,  X9,
  input  logic [DATA_W-1:0]  X10, X11, X12, X13,
  input  logic [DATA_W-1:0]  X14, X15, X16, X17,
  input  logic [DATA_W-1:0]  X18, X19,
  output logic [CLASS_W-1:0] out
);

  logic [NUM_FEATS-1:0][DATA_W-1:0] feat_raw, feat_eval;
  walk_t                            walk [MAX_DEPTH+1];
  logic [CLASS_W-1:0]               out_d, out_q;
  logic                             unused_idx;

  always_comb begin
    feat_raw     = '0;
    feat_raw[0]  = X0;  feat_raw[1]  = X1;  feat_raw[2]  = X2;  feat_raw[3]  = X3;
    feat_raw[6]  = X6;  feat_raw[7]  = X7;  feat_raw[8]  = X8;  feat_raw[9]  = X9;
    feat_raw[10] = X10; feat_raw[11] = X11; feat_raw[12] = X12; feat_raw[13] = X13;
    feat_raw[14] = X14; feat_raw[15] = X15; feat_raw[16] = X16; feat_raw[17] = X17;
    feat_raw[18] = X18; feat_raw[19] = X19;
  end

`ifdef DTREE_IN_REG_EN
  logic [NUM_FEATS-1:0][DATA_W-1:0] feat_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) feat_q <= '0;
    else        feat_q <= feat_raw;

  assign feat_eval = feat_q;
`else
  assign feat_eval = feat_raw;
`endif

  assign walk[0] = '{done: 1'b0, idx: '0, cls: '0};

  for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_lvl
    dtree_node_eval #(
      .DATA_W    (DATA_W),
      .NUM_NODES (NUM_NODES),
      .DEF_CLASS (DEF_CLASS)
    ) u_node (
      .feats_i (feat_eval),
      .walk_i  (walk[g]),
      .walk_o  (walk[g+1])
    );
  end

  // Still unresolved after MAX_DEPTH comparisons means the table is malformed.
  assign out_d = walk[MAX_DEPTH].done ? CLASS_W'(walk[MAX_DEPTH].cls)
                                      : CLASS_W'(DEF_CLASS);
  assign unused_idx = ^walk[MAX_DEPTH].idx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;

  assign out = out_q;

endmodule

// File: tb/tb_cardio_dtree_classifier.sv
module tb_cardio_dtree_classifier;

`ifdef DTREE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [19:0][7:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  vec_t       xv = '0;
  logic [1:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [1:0] cls; string tag; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cardio_dtree_classifier dut (
    .clk(clk), .rst_n(rst_n),
    .X0(xv[0]),   .X1(xv[1]),   .X2(xv[2]),   .X3(xv[3]),
    .X6(xv[6]),   .X7(xv[7]),   .X8(xv[8]),   .X9(xv[9]),
    .X10(xv[10]), .X11(xv[11]), .X12(xv[12]), .X13(xv[13]),
    .X14(xv[14]), .X15(xv[15]), .X16(xv[16]), .X17(xv[17]),
    .X18(xv[18]), .X19(xv[19]),
    .out(out)
  );

  // Reference tree written directly from the node description.
  function automatic logic [1:0] model(input vec_t v);
    if (v[8] <= 8'd100) return (v[1] <= 8'd20) ? 2'd1 : 2'd0;
    else                return (v[17] <= 8'd50) ? 2'd2 : 2'd1;
  endfunction

  function automatic vec_t mk(input logic [7:0] x1, input logic [7:0] x8,
                              input logic [7:0] x17);
    vec_t v;
    v = '0;
    v[1] = x1; v[8] = x8; v[17] = x17;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    for (int i = 0; i < 20; i++) v[i] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic check(input string tag, input logic [1:0] exp);
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, out, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check(e.tag, e.cls);
  endtask

  // One cycle: compare the oldest result that has reached out, then drive v.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == LAT) pop_check();
    xv = v;
    e.cls = model(v); e.tag = tag;
    sb.push_back(e);
  endtask

  // Release reset at a negedge with v on the inputs. With the input register
  // the first loaded result is the class of the zeroed register contents.
  task automatic release_rst(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    xv = v;
    rst_n = 1'b1;
    sb.delete();
    if (LAT == 2) begin
      e.cls = model('0); e.tag = "post_rst_zero";
      sb.push_back(e);
    end
    e.cls = model(v); e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clk);
      pop_check();
    end
  endtask

  initial begin
    // Reset asserted from time zero with arbitrary inputs: out cleared with no edge.
    xv = rnd();
    #1 check("reset_async_t0", 2'd0);
    @(negedge clk) check("reset_held", 2'd0);

    // Boundary vectors, released straight into the stream.
    release_rst(mk(8'd20, 8'd100, 8'd0), "x8eq100_x1eq20");
    apply(mk(8'd21, 8'd100, 8'd0),  "x8eq100_x1eq21");
    apply(mk(8'd0,  8'd0,   8'd0),  "x8_0_x1_0");
    apply(mk(8'd0,  8'd101, 8'd50), "x8eq101_x17eq50");
    apply(mk(8'd0,  8'd255, 8'd51), "x8_255_x17eq51");

    // Back-to-back mix of directed and random vectors.
    apply(mk(8'd20, 8'd100, 8'd0),  "b2b_suspect");
    apply(mk(8'd0,  8'd101, 8'd50), "b2b_patho");
    apply(mk(8'd21, 8'd100, 8'd0),  "b2b_normal");
    apply(mk(8'd0,  8'd255, 8'd51), "b2b_suspect_r");
    apply(mk(8'd255, 8'd0,  8'd255), "b2b_x1max");
    for (int i = 0; i < 24; i++) apply(rnd(), "random");

    // Stream of class-2 vectors, then reset pulse mid-cycle.
    apply(mk(8'd0, 8'd101, 8'd50), "pre_rst_patho_a");
    apply(mk(8'd0, 8'd101, 8'd50), "pre_rst_patho_b");
    drain();
    check("pre_rst_level", 2'd2);
    #2 rst_n = 1'b0;
    #1 check("reset_async_mid", 2'd0);
    @(negedge clk) check("reset_mid_held", 2'd0);
    release_rst(mk(8'd0, 8'd101, 8'd50), "post_rst_patho");
    apply(mk(8'd30, 8'd50, 8'd0), "post_rst_normal");
    apply(rnd(), "post_rst_random");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
